// File: rtl/tile_sel_gen_pkg.sv
// Shared constants and types for the tile/sprite select generator.
// The tile codes map onto the inputs of the RGB mux that follows this block.
package tile_sel_gen_pkg;

    localparam int TILE_W = 32;
    localparam int GRID_W = 20;
    localparam int GRID_H = 15;

    localparam logic [3:0] T_PATH = 4'd0;
    localparam logic [3:0] T_SURR = 4'd1;
    localparam logic [3:0] T_OBS1 = 4'd2;
    localparam logic [3:0] T_OBS2 = 4'd3;
    localparam logic [3:0] T_BOMB = 4'd4;
    localparam logic [3:0] T_EXPL = 4'd5;
    localparam logic [3:0] T_PLR1 = 4'd6;
    localparam logic [3:0] T_PLR2 = 4'd7;
    localparam logic [3:0] T_NONE = 4'hF;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } timing_t;

    // Map codes 6 and 7 are player codes and must never come from the map RAM.
    function automatic logic [3:0] map_code_sel(input logic [2:0] code);
        logic [3:0] sel;
        case (code)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5: sel = {1'b0, code};
            default:                            sel = T_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/tile_sel_gen_sprite_hit.sv
// 32x32 sprite hit test and in-sprite offset for one player.
// Compared in 12 bits so a sprite near the right/bottom edge never wraps.
module sprite_hit (
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic [10:0] pos_x,
    input  logic [10:0] pos_y,
    output logic        hit,
    output logic [9:0]  offset
);

    logic [11:0] x_end_s;
    logic [11:0] y_end_s;
    logic [4:0]  dx_s;
    logic [4:0]  dy_s;

    // Bounds compare and low-bit offset subtraction (only 5 bits matter inside a hit).
    always_comb begin
        x_end_s = {1'b0, pos_x} + 12'd31;
        y_end_s = {1'b0, pos_y} + 12'd31;
        hit     = ({1'b0, hcount} >= {1'b0, pos_x}) && ({1'b0, hcount} <= x_end_s) &&
                  ({1'b0, vcount} >= {1'b0, pos_y}) && ({1'b0, vcount} <= y_end_s);
        dx_s    = hcount[4:0] - pos_x[4:0];
        dy_s    = vcount[4:0] - pos_y[4:0];
        offset  = {dy_s, dx_s};
    end

endmodule

// File: rtl/tile_sel_gen.sv
// Two-stage pixel pipeline: map/ROM addressing in stage 1, mux select in stage 2.
// Timing signals are delayed LAT cycles so they leave aligned with o_sel.
module tile_sel_gen #(
    parameter int TILE_W = tile_sel_gen_pkg::TILE_W,
    parameter int GRID_W = tile_sel_gen_pkg::GRID_W,
    parameter int GRID_H = tile_sel_gen_pkg::GRID_H,
    parameter int LAT    = 2
) (
    input  logic        i_pclk,
    input  logic        i_rst_n,
    input  logic [10:0] i_hcount,
    input  logic [10:0] i_vcount,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic        i_hblnk,
    input  logic        i_vblnk,
    input  logic [2:0]  i_map_data,
    input  logic [10:0] i_plr1_x,
    input  logic [10:0] i_plr1_y,
    input  logic [10:0] i_plr2_x,
    input  logic [10:0] i_plr2_y,
    output logic [8:0]  o_map_addr,
    output logic [9:0]  o_rom_addr,
    output logic [3:0]  o_sel,
    output logic [10:0] o_hcount,
    output logic [10:0] o_vcount,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_hblnk,
    output logic        o_vblnk
);

    import tile_sel_gen_pkg::*;

    localparam int TW_LOG = $clog2(TILE_W);

    logic        frame_start_s;
    logic [10:0] p1x_s, p1y_s, p2x_s, p2y_s;
    logic [10:0] p1x_r, p1y_r, p2x_r, p2y_r;
    logic [10:0] col_s, row_s;
    logic        in_grid_s;
    logic [8:0]  lin_addr_s;
    logic [8:0]  map_addr_s;
    logic [9:0]  rom_addr_s;
    logic        hit1_s, hit2_s;
    logic [9:0]  off1_s, off2_s;
    logic        hit1_r, hit2_r, blank1_r, in_grid1_r;
    logic [3:0]  sel_s;
    timing_t     timing_s;
    timing_t     tdly_r [LAT];

    // The frame-start pixel already sees the freshly latched positions.
    always_comb begin
        frame_start_s = (i_hcount == 11'd0) && (i_vcount == 11'd0);
        if (frame_start_s) begin
            p1x_s = i_plr1_x;
            p1y_s = i_plr1_y;
            p2x_s = i_plr2_x;
            p2y_s = i_plr2_y;
        end else begin
            p1x_s = p1x_r;
            p1y_s = p1y_r;
            p2x_s = p2x_r;
            p2y_s = p2y_r;
        end
    end

    sprite_hit u_hit1 (
        .hcount (i_hcount),
        .vcount (i_vcount),
        .pos_x  (p1x_s),
        .pos_y  (p1y_s),
        .hit    (hit1_s),
        .offset (off1_s)
    );

    sprite_hit u_hit2 (
        .hcount (i_hcount),
        .vcount (i_vcount),
        .pos_x  (p2x_s),
        .pos_y  (p2y_s),
        .hit    (hit2_s),
        .offset (off2_s)
    );

    // Stage-1 address generation; off-grid pixels park the map address at 0.
    always_comb begin
        col_s      = i_hcount >> TW_LOG;
        row_s      = i_vcount >> TW_LOG;
        in_grid_s  = (col_s < 11'(GRID_W)) && (row_s < 11'(GRID_H));
        lin_addr_s = 9'(32'(row_s) * 32'(GRID_W) + 32'(col_s));
        if (in_grid_s) begin
            map_addr_s = lin_addr_s;
        end else begin
            map_addr_s = 9'd0;
        end
        if (hit1_s) begin
            rom_addr_s = off1_s;
        end else if (hit2_s) begin
            rom_addr_s = off2_s;
        end else begin
            rom_addr_s = {i_vcount[4:0], i_hcount[4:0]};
        end
        timing_s = '{hcount: i_hcount, vcount: i_vcount, hsync: i_hsync,
                     vsync: i_vsync, hblnk: i_hblnk, vblnk: i_vblnk};
    end

    // Stage-1 registers and the per-frame shadow positions.
    always_ff @(posedge i_pclk) begin
        if (!i_rst_n) begin
            o_map_addr <= 9'd0;
            o_rom_addr <= 10'd0;
            hit1_r     <= 1'b0;
            hit2_r     <= 1'b0;
            blank1_r   <= 1'b0;
            in_grid1_r <= 1'b0;
            p1x_r      <= 11'd0;
            p1y_r      <= 11'd0;
            p2x_r      <= 11'd0;
            p2y_r      <= 11'd0;
        end else begin
            o_map_addr <= map_addr_s;
            o_rom_addr <= rom_addr_s;
            hit1_r     <= hit1_s;
            hit2_r     <= hit2_s;
            blank1_r   <= i_hblnk | i_vblnk;
            in_grid1_r <= in_grid_s;
            p1x_r      <= p1x_s;
            p1y_r      <= p1y_s;
            p2x_r      <= p2x_s;
            p2y_r      <= p2y_s;
        end
    end

    // Stage-2 select; i_map_data here is the map RAM reply for the stage-1 address.
    always_comb begin
        if (blank1_r) begin
            sel_s = T_NONE;
        end else if (!in_grid1_r) begin
            sel_s = T_NONE;
        end else if (hit1_r) begin
            sel_s = T_PLR1;
        end else if (hit2_r) begin
            sel_s = T_PLR2;
        end else begin
            sel_s = map_code_sel(i_map_data);
        end
    end

    // Stage-2 select register.
    always_ff @(posedge i_pclk) begin
        if (!i_rst_n) begin
            o_sel <= T_NONE;
        end else begin
            o_sel <= sel_s;
        end
    end

    // LAT-deep delay line for the VGA timing signals.
    always_ff @(posedge i_pclk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                tdly_r[i] <= '0;
            end
        end else begin
            tdly_r[0] <= timing_s;
            for (int i = 1; i < LAT; i++) begin
                tdly_r[i] <= tdly_r[i-1];
            end
        end
    end

    assign o_hcount = tdly_r[LAT-1].hcount;
    assign o_vcount = tdly_r[LAT-1].vcount;
    assign o_hsync  = tdly_r[LAT-1].hsync;
    assign o_vsync  = tdly_r[LAT-1].vsync;
    assign o_hblnk  = tdly_r[LAT-1].hblnk;
    assign o_vblnk  = tdly_r[LAT-1].vblnk;

endmodule

// File: tb/tb_tile_sel_gen.sv
// Bench for tile_sel_gen: hand-derived vector table, corner sequences and a
// randomized pixel stream checked against a rule-level reference model.
module tb_tile_sel_gen;

    logic        i_pclk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [10:0] i_hcount = 11'd0, i_vcount = 11'd0;
    logic        i_hsync = 1'b0, i_vsync = 1'b0, i_hblnk = 1'b0, i_vblnk = 1'b0;
    logic [2:0]  i_map_data = 3'd0;
    logic [10:0] i_plr1_x = 11'd0, i_plr1_y = 11'd0, i_plr2_x = 11'd0, i_plr2_y = 11'd0;
    logic [8:0]  o_map_addr;
    logic [9:0]  o_rom_addr;
    logic [3:0]  o_sel;
    logic [10:0] o_hcount, o_vcount;
    logic        o_hsync, o_vsync, o_hblnk, o_vblnk;

    tile_sel_gen dut (
        .i_pclk(i_pclk), .i_rst_n(i_rst_n), .i_hcount(i_hcount), .i_vcount(i_vcount),
        .i_hsync(i_hsync), .i_vsync(i_vsync), .i_hblnk(i_hblnk), .i_vblnk(i_vblnk),
        .i_map_data(i_map_data), .i_plr1_x(i_plr1_x), .i_plr1_y(i_plr1_y),
        .i_plr2_x(i_plr2_x), .i_plr2_y(i_plr2_y), .o_map_addr(o_map_addr),
        .o_rom_addr(o_rom_addr), .o_sel(o_sel), .o_hcount(o_hcount), .o_vcount(o_vcount),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_hblnk(o_hblnk), .o_vblnk(o_vblnk)
    );

    always #5 i_pclk = ~i_pclk;

    typedef struct {
        int h, v;
        bit hs, vs, hb, vb;
        int p1x, p1y, p2x, p2y;
    } pix_t;

    typedef struct {
        int addr, rom;
        bit blank, ingrid, hit1, hit2;
        int h, v, flags;
    } exp_t;

    typedef struct {
        string name;
        int h, v, hb, p1x, p1y, p2x, p2y, code, eaddr, erom, esel;
    } vec_t;

    int     n_checks = 0;
    int     n_errors = 0;
    int     mem [512];
    int     sh1x = 0, sh1y = 0, sh2x = 0, sh2y = 0;
    exp_t   last_e;
    bit     last_valid = 1'b0;
    vec_t   vecs [10];

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic bit inside_spr(input int h, input int v, input int px, input int py);
        return (h >= px) && (h <= px + 31) && (v >= py) && (v <= py + 31);
    endfunction

    // Reference: tile geometry, 32x32 sprites, player 1 priority.
    function automatic exp_t model(input pix_t p);
        exp_t e;
        int col, row;
        col = p.h / 32;
        row = p.v / 32;
        e.ingrid = (col < 20) && (row < 15);
        e.addr   = e.ingrid ? row * 20 + col : 0;
        e.hit1   = inside_spr(p.h, p.v, sh1x, sh1y);
        e.hit2   = inside_spr(p.h, p.v, sh2x, sh2y);
        if (e.hit1)      e.rom = (p.v - sh1y) * 32 + (p.h - sh1x);
        else if (e.hit2) e.rom = (p.v - sh2y) * 32 + (p.h - sh2x);
        else             e.rom = (p.v % 32) * 32 + (p.h % 32);
        e.blank = p.hb || p.vb;
        e.h     = p.h;
        e.v     = p.v;
        e.flags = {28'd0, p.hs, p.vs, p.hb, p.vb};
        return e;
    endfunction

    function automatic int final_sel(input exp_t e, input int code);
        if (e.blank)   return 15;
        if (!e.ingrid) return 15;
        if (e.hit1)    return 6;
        if (e.hit2)    return 7;
        if (code <= 5) return code;
        return 15;
    endfunction

    task automatic drive(input pix_t p);
        i_hcount = 11'(p.h);  i_vcount = 11'(p.v);
        i_hsync  = p.hs;      i_vsync  = p.vs;
        i_hblnk  = p.hb;      i_vblnk  = p.vb;
        i_plr1_x = 11'(p.p1x); i_plr1_y = 11'(p.p1y);
        i_plr2_x = 11'(p.p2x); i_plr2_y = 11'(p.p2y);
    endtask

    // One pixel per clock; code_ovr >= 0 replaces the RAM reply for the previous pixel.
    task automatic step(input pix_t p, input int code_ovr);
        exp_t e;
        int   lc;
        lc = 0;
        drive(p);
        if (last_valid) begin
            lc = (code_ovr >= 0) ? code_ovr : mem[last_e.addr];
        end
        i_map_data = 3'(lc);
        if (p.h == 0 && p.v == 0) begin
            sh1x = p.p1x; sh1y = p.p1y; sh2x = p.p2x; sh2y = p.p2y;
        end
        e = model(p);
        @(posedge i_pclk); #1;
        chk("map_addr", int'(o_map_addr), e.addr);
        chk("rom_addr", int'(o_rom_addr), e.rom);
        if (last_valid) begin
            chk("sel", int'(o_sel), final_sel(last_e, lc));
            chk("hcount_dly", int'(o_hcount), last_e.h);
            chk("vcount_dly", int'(o_vcount), last_e.v);
            chk("flags_dly", int'({o_hsync, o_vsync, o_hblnk, o_vblnk}), last_e.flags);
        end
        last_e     = e;
        last_valid = 1'b1;
    endtask

    task automatic do_reset(input int n, input pix_t p);
        drive(p);
        i_rst_n = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge i_pclk); #1;
            chk("rst_sel", int'(o_sel), 15);
            chk("rst_map_addr", int'(o_map_addr), 0);
            chk("rst_rom_addr", int'(o_rom_addr), 0);
            chk("rst_timing", int'({o_hcount, o_vcount, o_hsync, o_vsync, o_hblnk, o_vblnk}), 0);
        end
        i_rst_n = 1'b1;
        sh1x = 0; sh1y = 0; sh2x = 0; sh2y = 0;
        last_valid = 1'b0;
    endtask

    function automatic pix_t mkpix(input int h, input int v, input bit hb, input int p1x,
                                   input int p1y, input int p2x, input int p2y);
        pix_t p;
        p = '{h: h, v: v, hs: 1'b0, vs: 1'b0, hb: hb, vb: 1'b0,
              p1x: p1x, p1y: p1y, p2x: p2x, p2y: p2y};
        return p;
    endfunction

    function automatic int clip(input int x);
        if (x < 0)    return 0;
        if (x > 2047) return 2047;
        return x;
    endfunction

    pix_t fill;
    pix_t rp;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = $urandom_range(0, 7);
        fill = mkpix(700, 500, 1'b1, 1500, 1500, 1500, 1500);
        fill.vb = 1'b1;

        vecs[0] = '{"tile_addr",      45,  70, 0, 1500, 1500, 1500, 1500, 3,  41,  205,  3};
        vecs[1] = '{"plr1_offset",   110, 205, 0,  100,  200, 1500, 1500, 0, 123,  170,  6};
        vecs[2] = '{"plr_overlap",   100, 200, 0,  100,  200,  100,  200, 0, 123,    0,  6};
        vecs[3] = '{"hblank",         45,  70, 1, 1500, 1500, 1500, 1500, 2,  41,  205, 15};
        vecs[4] = '{"map_code7",      45,  70, 0, 1500, 1500, 1500, 1500, 7,  41,  205, 15};
        vecs[5] = '{"plr2_corner",   331, 131, 0, 1500, 1500,  300,  100, 0,  90, 1023,  7};
        vecs[6] = '{"plr1_just_out", 332, 131, 0,  300,  100, 1500, 1500, 1,  90,  108,  1};
        vecs[7] = '{"col_oob",       650, 100, 0, 1500, 1500, 1500, 1500, 2,   0,  138, 15};
        vecs[8] = '{"row_oob",        10, 490, 0, 1500, 1500, 1500, 1500, 2,   0,  330, 15};
        vecs[9] = '{"map_code5",       0,  32, 0, 1500, 1500, 1500, 1500, 5,  20,    0,  5};

        do_reset(2, mkpix(45, 70, 1'b0, 0, 0, 0, 0));

        // Table: latch positions at frame start, apply pixel, feed the map code.
        for (int i = 0; i < 10; i++) begin
            step(mkpix(0, 0, 1'b0, vecs[i].p1x, vecs[i].p1y, vecs[i].p2x, vecs[i].p2y), -1);
            step(mkpix(vecs[i].h, vecs[i].v, vecs[i].hb[0], vecs[i].p1x, vecs[i].p1y,
                       vecs[i].p2x, vecs[i].p2y), -1);
            chk({vecs[i].name, "_addr"}, int'(o_map_addr), vecs[i].eaddr);
            chk({vecs[i].name, "_rom"}, int'(o_rom_addr), vecs[i].erom);
            step(fill, vecs[i].code);
            chk({vecs[i].name, "_sel"}, int'(o_sel), vecs[i].esel);
        end

        // Mid-frame position change is ignored until the next frame start.
        step(mkpix(0, 0, 1'b0, 50, 0, 1500, 1500), -1);
        step(mkpix(60, 10, 1'b0, 300, 0, 1500, 1500), -1);
        step(fill, 0);
        chk("latch_old_hit", int'(o_sel), 6);
        step(mkpix(310, 10, 1'b0, 300, 0, 1500, 1500), -1);
        step(fill, 0);
        chk("latch_new_not_yet", int'(o_sel), 0);
        step(mkpix(0, 0, 1'b0, 300, 0, 1500, 1500), -1);
        step(mkpix(310, 10, 1'b0, 300, 0, 1500, 1500), -1);
        step(fill, 0);
        chk("latch_new_hit", int'(o_sel), 6);

        // One-cycle reset mid-line, then the tile is correct at the 2nd edge.
        step(mkpix(200, 64, 1'b0, 300, 0, 1500, 1500), -1);
        do_reset(1, mkpix(201, 64, 1'b0, 300, 0, 1500, 1500));
        step(mkpix(45, 70, 1'b0, 300, 0, 1500, 1500), -1);
        step(fill, 3);
        chk("post_reset_tile", int'(o_sel), 3);
        step(mkpix(10, 10, 1'b0, 300, 0, 1500, 1500), -1);
        step(fill, 0);
        chk("post_reset_plr_at_origin", int'(o_sel), 6);

        // Randomized pixel stream with frame starts, sprite-near pixels and resets.
        for (int n = 0; n < 4000; n++) begin
            rp.p1x = $urandom_range(0, 700);
            rp.p1y = $urandom_range(0, 520);
            rp.p2x = ($urandom_range(0, 2) == 0) ? rp.p1x : int'($urandom_range(0, 700));
            rp.p2y = ($urandom_range(0, 2) == 0) ? rp.p1y : int'($urandom_range(0, 520));
            case ($urandom_range(0, 9))
                0: begin rp.h = 0; rp.v = 0; end
                1, 2: begin
                    rp.h = clip(sh1x + int'($urandom_range(0, 40)) - 4);
                    rp.v = clip(sh1y + int'($urandom_range(0, 40)) - 4);
                end
                3, 4: begin
                    rp.h = clip(sh2x + int'($urandom_range(0, 40)) - 4);
                    rp.v = clip(sh2y + int'($urandom_range(0, 40)) - 4);
                end
                default: begin
                    rp.h = $urandom_range(0, 799);
                    rp.v = $urandom_range(0, 524);
                end
            endcase
            rp.hs = $urandom_range(0, 1);
            rp.vs = $urandom_range(0, 1);
            rp.hb = (rp.h >= 640) ^ ($urandom_range(0, 7) == 0);
            rp.vb = (rp.v >= 480) ^ ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) begin
                do_reset(int'($urandom_range(1, 2)), rp);
            end else begin
                step(rp, -1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
